// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low glyph table, blank code, decoder FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index is the hex value; bit6 = seg a .. bit0 = seg g, 0 = lit.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {SETTLE, DECODE, PRESENT} state_t;

  typedef struct packed {
    logic [3:0] number;
    logic       blank;
    logic       error;
  } glyph_dec_t;

endpackage

// File: rtl/seg_glyph_to_hex.sv
// Combinational inverse glyph lookup: active-low pattern -> {number, blank, error}.
module seg_glyph_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output glyph_dec_t dec
);

  always_comb begin
    dec = '{number: 4'd0, blank: 1'b0, error: 1'b1};
    if (pattern == SEG_BLANK) begin
      dec.blank = 1'b1;
      dec.error = 1'b0;
    end else begin
      for (int v = 0; v < 16; v++) begin
        if (pattern == SEG_GLYPH[v]) begin
          dec.number = 4'(v);
          dec.error  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Round-robin 7-seg readback: waits for a stable pattern per digit, decodes it, presents a valid/ready result.
// Optional SEG_DECODE_ERR_CNT_EN adds an 8-bit saturating count of error transfers on err_count.
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 16,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] patterns_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [3:0]              out_number,
  output logic                    out_blank,
  output logic                    out_error
`ifdef SEG_DECODE_ERR_CNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [6:0]       sample_q;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       digit [NUM_DIGITS];
  logic [6:0]       cur;
  logic             stable_hit;
  logic             xfer;
  glyph_dec_t       dec;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digit[k] = patterns_in[7*k +: 7];
  end

  assign cur        = digit[idx];
  assign stable_hit = (cur == sample_q) && (cnt == CNT_LAST);

  seg_glyph_to_hex u_lookup (
    .pattern (sample_q),
    .dec     (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE:  if (stable_hit) state_nxt = DECODE;
      DECODE:  state_nxt = PRESENT;
      PRESENT: if (out_ready)  state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase
  end

  always_comb begin
    out_valid = (state == PRESENT);
    xfer      = out_valid && out_ready;
  end

  // Sampling, scan index and result snapshot; PRESENT ignores the bus entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sample_q   <= SEG_BLANK;
      cnt        <= '0;
      out_idx    <= '0;
      out_number <= '0;
      out_blank  <= 1'b0;
      out_error  <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cur != sample_q) begin
            sample_q <= cur;
            cnt      <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          out_number <= dec.number;
          out_blank  <= dec.blank;
          out_error  <= dec.error;
          out_idx    <= idx;
        end
        PRESENT: begin
          if (xfer) begin
            idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            cnt      <= '0;
            sample_q <= SEG_BLANK;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_DECODE_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err_count <= '0;
    else if (xfer && out_error && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder (NUM_DIGITS=4, STABLE_CYCLES=16); checks err_count when SEG_DECODE_ERR_CNT_EN is set.
module tb_seg_pattern_decoder;

  localparam int ND  = 4;
  localparam int SC  = 16;
  localparam int LAT = SC + 2;

  localparam logic [6:0] G0  = 7'b0000001;
  localparam logic [6:0] G2  = 7'b0010010;
  localparam logic [6:0] G3  = 7'b0000110;
  localparam logic [6:0] G5  = 7'b0100100;
  localparam logic [6:0] G8  = 7'b0000000;
  localparam logic [6:0] GF  = 7'b0111000;
  localparam logic [6:0] GBL = 7'b1111111;
  localparam logic [6:0] GER = 7'b1010101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7*ND-1:0] pats = '1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_idx;
  logic [3:0]    out_number;
  logic          out_blank;
  logic          out_error;
`ifdef SEG_DECODE_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int vcnt;

  seg_pattern_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .patterns_in (pats),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_number  (out_number),
    .out_blank   (out_blank),
    .out_error   (out_error)
`ifdef SEG_DECODE_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Counts edges until out_valid is seen; bounded so a dead DUT still reaches the summary.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 4 * LAT) begin
      tick;
      cycles++;
    end
    if (out_valid !== 1'b1) check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    // 1: all digits show 0, ready high, round-robin scan
    pats = {4{G0}};
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check("rst_valid",  {31'd0, out_valid}, 0);
    check("rst_idx",    {30'd0, out_idx}, 0);
    check("rst_number", {28'd0, out_number}, 0);
    check("rst_flags",  {30'd0, out_blank, out_error}, 0);
`ifdef SEG_DECODE_ERR_CNT_EN
    check("rst_errcnt", {24'd0, err_count}, 0);
`endif
    do_reset;
    for (int k = 0; k < 5; k++) begin
      wait_valid(lat);
      check("t1_lat",    lat, LAT);
      check("t1_idx",    {30'd0, out_idx}, k % ND);
      check("t1_number", {28'd0, out_number}, 0);
      check("t1_flags",  {30'd0, out_blank, out_error}, 0);
      tick;
      check("t1_drop",   {31'd0, out_valid}, 0);
    end

    // 2: backpressure holds a snapshot of F while the bus changes
    out_ready = 1'b0;
    pats = {G0, G0, G0, GF};
    do_reset;
    wait_valid(lat);
    check("t2_lat",    lat, LAT);
    check("t2_idx",    {30'd0, out_idx}, 0);
    check("t2_number", {28'd0, out_number}, 15);
    pats[6:0] = G8;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (out_valid === 1'b1 && out_number === 4'hF && out_idx === 2'd0) vcnt++;
    end
    check("t2_hold", vcnt, 10);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("t2_drop", {31'd0, out_valid}, 0);
    wait_valid(lat);
    check("t2_next_lat", lat, LAT);
    check("t2_next_idx", {30'd0, out_idx}, 1);

    // 3: glitching digit1 never completes; settling on 3 yields one result
    out_ready = 1'b1;
    pats = {G0, G0, G2, G0};
    do_reset;
    wait_valid(lat);
    tick;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      pats[13:7] = (i % 2 == 0) ? G3 : G2;
      for (int k = 0; k < 5; k++) begin
        tick;
        if (out_valid === 1'b1) vcnt++;
      end
    end
    check("t3_no_result", vcnt, 0);
    pats[13:7] = G3;
    wait_valid(lat);
    check("t3_lat",    lat, LAT);
    check("t3_idx",    {30'd0, out_idx}, 1);
    check("t3_number", {28'd0, out_number}, 3);

    // 4: blank and illegal patterns
    pats = {GER, GBL, G0, G0};
    do_reset;
    wait_valid(lat);
    tick;
    wait_valid(lat);
    tick;
    wait_valid(lat);
    check("t4_blank_idx",   {30'd0, out_idx}, 2);
    check("t4_blank_flags", {30'd0, out_blank, out_error}, 2);
    check("t4_blank_num",   {28'd0, out_number}, 0);
    tick;
    wait_valid(lat);
    check("t4_err_idx",   {30'd0, out_idx}, 3);
    check("t4_err_flags", {30'd0, out_blank, out_error}, 1);
    check("t4_err_num",   {28'd0, out_number}, 0);
`ifdef SEG_DECODE_ERR_CNT_EN
    check("t4_errcnt_pre", {24'd0, err_count}, 0);
`endif
    tick;
`ifdef SEG_DECODE_ERR_CNT_EN
    check("t4_errcnt", {24'd0, err_count}, 1);
`endif

    // 5: asynchronous reset mid-SETTLE and mid-PRESENT
    pats = {G0, G0, G5, GF};
    do_reset;
    wait_valid(lat);
    tick;
    repeat (5) tick;
    check("t5_pre_number", {28'd0, out_number}, 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5s_number", {28'd0, out_number}, 0);
    check("t5s_valid",  {31'd0, out_valid}, 0);
    out_ready = 1'b0;
    tick;
    rst_n = 1'b1;
    wait_valid(lat);
    check("t5s_restart_lat", lat, LAT);
    check("t5s_restart_idx", {30'd0, out_idx}, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    wait_valid(lat);
    check("t5p_idx",    {30'd0, out_idx}, 1);
    check("t5p_number", {28'd0, out_number}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5p_valid",  {31'd0, out_valid}, 0);
    check("t5p_idx0",   {30'd0, out_idx}, 0);
    check("t5p_number0", {28'd0, out_number}, 0);
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_valid(lat);
    check("t5p_restart_idx", {30'd0, out_idx}, 0);
    check("t5p_restart_num", {28'd0, out_number}, 15);

`ifdef SEG_DECODE_ERR_CNT_EN
    // 6: error counter saturates
    pats = {4{GER}};
    do_reset;
    for (int k = 0; k < 300; k++) begin
      wait_valid(lat);
      tick;
      if (k == 254) check("t6_errcnt_255", {24'd0, err_count}, 255);
      if (k == 100) check("t6_errcnt_101", {24'd0, err_count}, 101);
    end
    check("t6_errcnt_sat", {24'd0, err_count}, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
